control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_pkg.sv | 44 ++++
 rtl/alu_decoder.sv | 87 ++++++++
 rtl/control_unit.sv | 138 +++++++++++++
 tb/tb_control_unit.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// ---------------------------------------------------------------------------
// control_pkg
// Shared definitions for the multi-cycle control unit: FSM state encoding,
// decoded instruction kinds, MIPS-style opcode/funct constants and the ALU
// operation codes driven onto alu_op.
// ---------------------------------------------------------------------------
package control_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        K_NOP     = 2'd0,
        K_ALU     = 2'd1,
        K_HALT    = 2'd2,
        K_ILLEGAL = 2'd3
    } kind_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

endpackage

// File: rtl/alu_decoder.sv
// ---------------------------------------------------------------------------
// alu_decoder
// Purely combinational decode of the instruction register.
// Ports:
//   i_ir          32-bit instruction register contents
//   o_selecMux    destination select (1 = rd for R-type, 0 = rt)
//   o_selecMux2   ALU operand B select (1 = sign-extended immediate)
//   o_aluOp       ALU operation code
//   o_writes      instruction is a supported register-writing instruction
//   o_dest        destination register number (0 when nothing is written)
//   o_kind        NOP / ALU / HALT / ILLEGAL classification (kind_t)
// ---------------------------------------------------------------------------
module alu_decoder
    import control_pkg::*;
(
    input  logic [31:0] i_ir,
    output logic        o_selecMux,
    output logic        o_selecMux2,
    output logic [3:0]  o_aluOp,
    output logic        o_writes,
    output logic [4:0]  o_dest,
    output logic [1:0]  o_kind
);

    logic [5:0] w_opcode;
    logic [5:0] w_funct;
    logic       w_unusedBits;

    assign w_opcode = i_ir[31:26];
    assign w_funct  = i_ir[5:0];

    // rs, shamt and the immediate feed the datapath, not the control decode.
    assign w_unusedBits = ^{i_ir[25:21], i_ir[10:6]};

    // Everything starts out as an illegal, non-writing instruction with all
    // controls at zero; only recognised encodings switch anything on. The
    // all-zero word is the NOP and must be caught before the R-type branch,
    // since its funct field would otherwise look like an unknown R-type.
    always_comb begin
        o_selecMux  = 1'b0;
        o_selecMux2 = 1'b0;
        o_aluOp     = ALU_AND;
        o_writes    = 1'b0;
        o_dest      = 5'd0;
        o_kind      = K_ILLEGAL;
        if (i_ir == 32'h0000_0000) begin
            o_kind = K_NOP;
        end else begin
            case (w_opcode)
                OP_RTYPE: begin
                    o_kind     = K_ALU;
                    o_selecMux = 1'b1;
                    o_writes   = 1'b1;
                    o_dest     = i_ir[15:11];
                    case (w_funct)
                        FN_ADD:  o_aluOp = ALU_ADD;
                        FN_SUB:  o_aluOp = ALU_SUB;
                        FN_AND:  o_aluOp = ALU_AND;
                        FN_OR:   o_aluOp = ALU_OR;
                        FN_SLT:  o_aluOp = ALU_SLT;
                        default: begin
                            o_kind     = K_ILLEGAL;
                            o_selecMux = 1'b0;
                            o_writes   = 1'b0;
                            o_dest     = 5'd0;
                        end
                    endcase
                end
                OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
                    o_kind      = K_ALU;
                    o_selecMux2 = 1'b1;
                    o_writes    = 1'b1;
                    o_dest      = i_ir[20:16];
                    case (w_opcode)
                        OP_ANDI: o_aluOp = ALU_AND;
                        OP_ORI:  o_aluOp = ALU_OR;
                        OP_SLTI: o_aluOp = ALU_SLT;
                        default: o_aluOp = ALU_ADD;
                    endcase
                end
                OP_HALT: o_kind = K_HALT;
                default: o_kind = K_ILLEGAL;
            endcase
        end
    end

endmodule

// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit
// Multi-cycle control FSM: IDLE -> FETCH -> DECODE -> EXEC -> WB, plus an
// absorbing HALT state. Owns the instruction register and the retired /
// illegal / halted status.
// Ports:
//   clk, rst     rising-edge clock, active-low asynchronous reset
//   go           run request, sampled in IDLE and at the end of WB
//   instr        instruction word, latched into the IR at the end of FETCH
//   en           PC enable pulse (WB only)
//   en_rf        register-file write enable pulse (WB only)
//   selec_mux    destination select, valid in EXEC/WB
//   selec_mux2   ALU operand B select, valid in EXEC/WB
//   alu_op       ALU operation, valid in EXEC/WB
//   halted       high once a HALT instruction has retired
//   illegal      sticky flag for retired unsupported encodings
//   retired      16-bit wrapping count of retired instructions
// ---------------------------------------------------------------------------
module control_unit
    import control_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    input  logic [31:0] instr,
    output logic        en,
    output logic        en_rf,
    output logic        selec_mux,
    output logic        selec_mux2,
    output logic [3:0]  alu_op,
    output logic        halted,
    output logic        illegal,
    output logic [15:0] retired
);

    state_t      r_state;
    state_t      w_nextState;
    logic [31:0] r_ir;
    logic [15:0] r_retired;
    logic        r_illegal;

    logic        w_decMux;
    logic        w_decMux2;
    logic [3:0]  w_decAluOp;
    logic        w_decWrites;
    logic [4:0]  w_decDest;
    logic [1:0]  w_decKind;

    alu_decoder u_decoder (
        .i_ir        (r_ir),
        .o_selecMux  (w_decMux),
        .o_selecMux2 (w_decMux2),
        .o_aluOp     (w_decAluOp),
        .o_writes    (w_decWrites),
        .o_dest      (w_decDest),
        .o_kind      (w_decKind)
    );

    // State register. Because every control output is decoded from the
    // state alone, the asynchronous reset forcing IDLE also kills any
    // en/en_rf pulse that was in flight in WB.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and control outputs. Decoded controls are only exposed in
    // EXEC and WB; the register write additionally requires a nonzero
    // destination so writes to $0 never reach the register file.
    always_comb begin
        w_nextState = r_state;
        en          = 1'b0;
        en_rf       = 1'b0;
        selec_mux   = 1'b0;
        selec_mux2  = 1'b0;
        alu_op      = ALU_AND;
        case (r_state)
            S_IDLE: begin
                if (go) begin
                    w_nextState = S_FETCH;
                end
            end
            S_FETCH:  w_nextState = S_DECODE;
            S_DECODE: w_nextState = S_EXEC;
            S_EXEC: begin
                selec_mux   = w_decMux;
                selec_mux2  = w_decMux2;
                alu_op      = w_decAluOp;
                w_nextState = S_WB;
            end
            S_WB: begin
                selec_mux  = w_decMux;
                selec_mux2 = w_decMux2;
                alu_op     = w_decAluOp;
                en         = 1'b1;
                en_rf      = w_decWrites && (w_decDest != 5'd0);
                if (w_decKind == K_HALT) begin
                    w_nextState = S_HALT;
                end else if (go) begin
                    w_nextState = S_FETCH;
                end else begin
                    w_nextState = S_IDLE;
                end
            end
            S_HALT:  w_nextState = S_HALT;
            default: w_nextState = S_IDLE;
        endcase
    end

    // Instruction register and retirement bookkeeping. The IR captures the
    // word presented during FETCH; every WB retires one instruction, and an
    // illegal one also sets the sticky flag. The counter wraps naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ir      <= 32'h0000_0000;
            r_retired <= 16'h0000;
            r_illegal <= 1'b0;
        end else begin
            if (r_state == S_FETCH) begin
                r_ir <= instr;
            end
            if (r_state == S_WB) begin
                r_retired <= r_retired + 16'd1;
                if (w_decKind == K_ILLEGAL) begin
                    r_illegal <= 1'b1;
                end
            end
        end
    end

    assign halted  = (r_state == S_HALT);
    assign illegal = r_illegal;
    assign retired = r_retired;

endmodule

// File: tb/tb_control_unit.sv
// ---------------------------------------------------------------------------
// tb_control_unit
// Self-checking bench for control_unit: directed instructions, a randomized
// instruction mix, reset during WB, retired-counter wrap and HALT.
// ---------------------------------------------------------------------------
module tb_control_unit;

    logic        clk;
    logic        rst;
    logic        go;
    logic [31:0] instr;
    logic        en;
    logic        en_rf;
    logic        selec_mux;
    logic        selec_mux2;
    logic [3:0]  alu_op;
    logic        halted;
    logic        illegal;
    logic [15:0] retired;

    int checkCount;
    int errCount;
    int modelRetired;
    int modelIllegal;

    int rFunct [5] = '{32, 34, 36, 37, 42};
    int rAlu   [5] = '{2, 6, 0, 1, 7};
    int iOpc   [4] = '{8, 12, 13, 10};
    int iAlu   [4] = '{2, 0, 1, 7};

    control_unit dut (
        .clk        (clk),
        .rst        (rst),
        .go         (go),
        .instr      (instr),
        .en         (en),
        .en_rf      (en_rf),
        .selec_mux  (selec_mux),
        .selec_mux2 (selec_mux2),
        .alu_op     (alu_op),
        .halted     (halted),
        .illegal    (illegal),
        .retired    (retired)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single point of comparison: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Reference decode: looks the word up in tables of supported opcodes and
    // functs and derives what the control outputs should be in EXEC/WB.
    task automatic modelDecode(input logic [31:0] w, output int eAlu, output int eMux,
                               output int eMux2, output int eWrite, output int eIll,
                               output int eHalt);
        int opc;
        int fn;
        opc    = int'(w[31:26]);
        fn     = int'(w[5:0]);
        eAlu   = 0;
        eMux   = 0;
        eMux2  = 0;
        eWrite = 0;
        eIll   = 1;
        eHalt  = 0;
        if (w == 32'h0) begin
            eIll = 0;
        end else if (opc == 63) begin
            eIll  = 0;
            eHalt = 1;
        end else if (opc == 0) begin
            for (int k = 0; k < 5; k++) begin
                if (rFunct[k] == fn) begin
                    eIll   = 0;
                    eMux   = 1;
                    eAlu   = rAlu[k];
                    eWrite = (w[15:11] != 5'd0) ? 1 : 0;
                end
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (iOpc[k] == opc) begin
                    eIll   = 0;
                    eMux2  = 1;
                    eAlu   = iAlu[k];
                    eWrite = (w[20:16] != 5'd0) ? 1 : 0;
                end
            end
        end
    endtask

    // Runs one instruction starting from IDLE with go low, checking every
    // phase. go is dropped during FETCH, so the instruction must still run
    // to completion and then return to IDLE.
    task automatic applyStimulus(input logic [31:0] word);
        int eAlu, eMux, eMux2, eWrite, eIll, eHalt;
        modelDecode(word, eAlu, eMux, eMux2, eWrite, eIll, eHalt);
        @(negedge clk);
        go    = 1'b1;
        instr = word;
        @(negedge clk);
        checkOutput("fetch_ctrl", {alu_op, selec_mux, selec_mux2, en, en_rf}, 32'h0);
        go = 1'b0;
        @(negedge clk);
        checkOutput("decode_ctrl", {alu_op, selec_mux, selec_mux2, en, en_rf}, 32'h0);
        instr = $urandom;
        @(negedge clk);
        checkOutput("exec_alu_op", alu_op, eAlu);
        checkOutput("exec_sel", {selec_mux, selec_mux2}, {eMux[0], eMux2[0]});
        checkOutput("exec_en", {en, en_rf}, 32'h0);
        @(negedge clk);
        checkOutput("wb_alu_op", alu_op, eAlu);
        checkOutput("wb_sel", {selec_mux, selec_mux2}, {eMux[0], eMux2[0]});
        checkOutput("wb_en", en, 1);
        checkOutput("wb_en_rf", en_rf, eWrite);
        @(negedge clk);
        modelRetired = (modelRetired + 1) % 65536;
        if (eIll != 0) modelIllegal = 1;
        checkOutput("after_retired", retired, modelRetired);
        checkOutput("after_illegal", illegal, modelIllegal);
        checkOutput("after_halted", halted, eHalt);
        checkOutput("after_en", {en, en_rf}, 32'h0);
    endtask

    // Random instruction: valid R-type, valid I-type, NOP, or arbitrary word,
    // never HALT so the random phase cannot stop the machine early.
    function automatic logic [31:0] genWord();
        logic [31:0] w;
        logic [5:0]  f;
        int          idx;
        case ($urandom_range(0, 3))
            0: begin
                idx = $urandom_range(0, 4);
                f   = 6'(rFunct[idx]);
                w   = {6'b000000, 5'($urandom), 5'($urandom), 5'($urandom), 5'b00000, f};
            end
            1: begin
                idx = $urandom_range(0, 3);
                f   = 6'(iOpc[idx]);
                w   = {f, 5'($urandom), 5'($urandom), 16'($urandom)};
            end
            2: w = 32'h0;
            default: w = $urandom;
        endcase
        if (w[31:26] == 6'h3F) w[31] = 1'b0;
        return w;
    endfunction

    initial begin
        int enCount;
        int eAlu, eMux, eMux2, eWrite, eIll, eHalt;
        checkCount   = 0;
        errCount     = 0;
        modelRetired = 0;
        modelIllegal = 0;
        rst   = 1'b0;
        go    = 1'b0;
        instr = 32'h0;

        #12;
        checkOutput("reset_ctrl", {alu_op, selec_mux, selec_mux2, en, en_rf}, 32'h0);
        checkOutput("reset_status", {halted, illegal}, 32'h0);
        checkOutput("reset_retired", retired, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        $display("[TB] directed instructions");

        applyStimulus(32'h2001_0005);
        applyStimulus(32'h0022_1820);
        applyStimulus(32'h2000_0007);
        applyStimulus(32'h0000_0000);
        applyStimulus(32'h8C01_0000);

        $display("[TB] random instruction mix");
        for (int n = 0; n < 40; n++) begin
            applyStimulus(genWord());
        end

        $display("[TB] reset during WB");
        modelDecode(32'h2001_0005, eAlu, eMux, eMux2, eWrite, eIll, eHalt);
        @(negedge clk);
        go    = 1'b1;
        instr = 32'h2001_0005;
        @(negedge clk);
        go = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checkOutput("pre_reset_wb_en", {en, en_rf}, {en, eWrite[0]} | 32'h2);
        #1 rst = 1'b0;
        #1;
        checkOutput("rst_wb_en", {en, en_rf}, 32'h0);
        checkOutput("rst_wb_retired", retired, 32'h0);
        checkOutput("rst_wb_status", {halted, illegal, alu_op}, 32'h0);
        @(negedge clk);
        rst          = 1'b1;
        modelRetired = 0;
        modelIllegal = 0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("post_rst_idle", {alu_op, selec_mux, selec_mux2, en, en_rf, retired}, 32'h0);
        applyStimulus(32'h0000_0000);

        $display("[TB] retired counter wrap with back-to-back NOPs");
        enCount = 0;
        @(negedge clk);
        go    = 1'b1;
        instr = 32'h0;
        for (int n = 1; n <= 262144; n++) begin
            @(negedge clk);
            if (en) enCount++;
            if (n == 262141) begin
                checkOutput("wrap_ffff", retired, (modelRetired + 65535) % 65536);
            end
            if (n == 262144) begin
                checkOutput("wrap_last_wb_en", en, 1);
                go = 1'b0;
            end
        end
        @(negedge clk);
        modelRetired = (modelRetired + 65536) % 65536;
        checkOutput("wrap_retired", retired, modelRetired);
        checkOutput("wrap_en_count", enCount, 65536);
        checkOutput("wrap_illegal", illegal, modelIllegal);

        $display("[TB] HALT");
        applyStimulus(32'hFC00_0000);
        @(negedge clk);
        go    = 1'b1;
        instr = 32'h2001_0005;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            checkOutput("halt_en", {en, en_rf}, 32'h0);
            checkOutput("halt_flag", halted, 1);
        end
        checkOutput("halt_retired", retired, modelRetired);

        $display("CHECKS %0d ERRORS %0d", checkCount, errCount);
        $finish;
    end

endmodule
